main_memory_responder: RTL and testbench

//  Backing-store responder for the cache datapath's memory port: accepts one word request
//   (read, or write-back of a dirty line) and completes it after a fixed multi-cycle latency.

---
 rtl/mem_pkg.sv | 14 +
 rtl/mem_storage.sv | 28 ++
 rtl/main_memory_responder.sv | 128 ++++++++++++
 tb/tb_main_memory_responder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the main memory responder: 4-lane byte word and FSM state.
package mem_pkg;

    localparam int MEM_LANES = 4;

    typedef logic [7:0] mem_word_t [0:MEM_LANES-1];

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mem_state_t;

endpackage

// File: rtl/mem_storage.sv
// Backing array for the responder: 2**ADDR_W words, synchronous write and registered read, no reset.
module mem_storage
    import mem_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [ADDR_W-1:0] raddr,
    input  mem_word_t         wdata,
    output mem_word_t         rdata
);

    mem_word_t mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < MEM_LANES; i++) begin
                mem[waddr][i] <= wdata[i];
            end
        end
        for (int unsigned i = 0; i < MEM_LANES; i++) begin
            rdata[i] <= mem[raddr][i];
        end
    end

endmodule

// File: rtl/main_memory_responder.sv
// Fixed-latency word responder for the cache memory port (IDLE -> BUSY -> DONE).
// Optional MEM_RANGE_CHECK_EN: reject addresses beyond the storage depth with mem_err.
module main_memory_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  mem_word_t   mem_data_in,
    output mem_word_t   mem_data_out,
    output logic        mem_ready,
    output logic        mem_busy,
    output logic        mem_err
);

    mem_state_t        state, state_n;
    logic [7:0]        count, count_n;
    logic              busy_n, ready_n, err_n;
    mem_word_t         dout_n;
    logic              load, complete;

    logic              we_q;
    logic [ADDR_W-1:0] idx_q;
    mem_word_t         data_q;
    logic              bad_q;

    logic              range_bad;
    logic              unused_addr_bits;
    logic              store_we;
    logic [ADDR_W-1:0] raddr;
    mem_word_t         rdata;

`ifdef MEM_RANGE_CHECK_EN
    assign range_bad        = |mem_addr[31:ADDR_W+2];
    assign unused_addr_bits = ^mem_addr[1:0];
`else
    assign range_bad        = 1'b0;
    assign unused_addr_bits = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0]};
`endif

    // Read address follows the live input while idle so the registered read
    // already holds the target word when LATENCY is 1.
    assign raddr    = (state == IDLE) ? mem_addr[ADDR_W+1:2] : idx_q;
    assign store_we = complete && we_q && !bad_q && rst_b;

    mem_storage #(
        .ADDR_W (ADDR_W)
    ) u_storage (
        .clk   (clk),
        .we    (store_we),
        .waddr (idx_q),
        .raddr (raddr),
        .wdata (data_q),
        .rdata (rdata)
    );

    always_comb begin
        state_n  = state;
        count_n  = count;
        busy_n   = mem_busy;
        ready_n  = 1'b0;
        err_n    = 1'b0;
        dout_n   = mem_data_out;
        load     = 1'b0;
        complete = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req) begin
                    load    = 1'b1;
                    count_n = 8'(LATENCY - 1);
                    busy_n  = 1'b1;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (count != '0) begin
                    count_n = count - 8'd1;
                end else begin
                    complete = 1'b1;
                    ready_n  = 1'b1;
                    err_n    = bad_q;
                    state_n  = DONE;
                    if (bad_q)     dout_n = '{default: 8'h00};
                    else if (we_q) dout_n = data_q;
                    else           dout_n = rdata;
                end
            end
            DONE: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state        <= IDLE;
            count        <= '0;
            mem_ready    <= 1'b0;
            mem_busy     <= 1'b0;
            mem_err      <= 1'b0;
            mem_data_out <= '{default: 8'h00};
        end else begin
            state        <= state_n;
            count        <= count_n;
            mem_ready    <= ready_n;
            mem_busy     <= busy_n;
            mem_err      <= err_n;
            mem_data_out <= dout_n;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            we_q   <= mem_we;
            idx_q  <= mem_addr[ADDR_W+1:2];
            data_q <= mem_data_in;
            bad_q  <= range_bad;
        end
    end

endmodule

// File: tb/tb_main_memory_responder.sv
// Self-checking bench for main_memory_responder: vector table, corner sequences, randomized traffic.
module tb_main_memory_responder;
    import mem_pkg::*;

    localparam int AW  = 12;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        req, we;
    logic [31:0] addr;
    mem_word_t   din, dout;
    logic        ready, busy, err;

    logic        req1, we1;
    logic [31:0] addr1;
    mem_word_t   din1, dout1;
    logic        ready1, busy1, err1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] model [int];

    always #5 clk = ~clk;

    main_memory_responder #(.ADDR_W(AW), .LATENCY(LAT)) dut (
        .clk(clk), .rst_b(rst_b), .mem_req(req), .mem_we(we), .mem_addr(addr),
        .mem_data_in(din), .mem_data_out(dout), .mem_ready(ready), .mem_busy(busy), .mem_err(err)
    );

    main_memory_responder #(.ADDR_W(4), .LATENCY(1)) dut1 (
        .clk(clk), .rst_b(rst_b), .mem_req(req1), .mem_we(we1), .mem_addr(addr1),
        .mem_data_in(din1), .mem_data_out(dout1), .mem_ready(ready1), .mem_busy(busy1), .mem_err(err1)
    );

    function automatic mem_word_t to_word(input logic [31:0] v);
        mem_word_t w;
        w[0] = v[31:24]; w[1] = v[23:16]; w[2] = v[15:8]; w[3] = v[7:0];
        return w;
    endfunction

    function automatic logic [31:0] from_word(input mem_word_t w);
        return {w[0], w[1], w[2], w[3]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level expectation: a word store indexed by address/4, with optional range rejection.
    task automatic model_txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                             output bit known, output logic [31:0] ed, output bit ee);
        int idx;
        idx = int'(a[AW+1:2]);
        ee = 1'b0;
`ifdef MEM_RANGE_CHECK_EN
        if (a[31:AW+2] != 0) begin
            known = 1'b1; ed = 32'h0; ee = 1'b1;
            return;
        end
`endif
        if (w) begin
            model[idx] = d; known = 1'b1; ed = d;
        end else if (model.exists(idx)) begin
            known = 1'b1; ed = model[idx];
        end else begin
            known = 1'b0; ed = 32'h0;
        end
    endtask

    task automatic txn(input string name, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input bit perturb, input logic [31:0] p_addr,
                       input bit chk_data, input logic [31:0] exp_d, input bit exp_e);
        int n;
        bit seen;
        req = 1'b1; we = w; addr = a; din = to_word(d);
        step();
        check({name, " busy_on_accept"}, 32'(busy), 32'd1);
        if (perturb) begin
            addr = p_addr; we = ~w; din = to_word(~d);
        end
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            step();
            n++;
            if (ready) seen = 1'b1;
        end
        check({name, " latency"}, 32'(n), 32'(LAT));
        if (seen) begin
            if (chk_data) check({name, " data_out"}, from_word(dout), exp_d);
            check({name, " err"}, 32'(err), 32'(exp_e));
        end
        req = 1'b0;
        step();
        check({name, " ready_drop"}, 32'(ready), 32'd0);
        check({name, " busy_drop"}, 32'(busy), 32'd0);
    endtask

    task automatic model_and_txn(input string name, input bit w, input logic [31:0] a,
                                 input logic [31:0] d, input bit perturb, input logic [31:0] p_addr);
        bit known, ee;
        logic [31:0] ed;
        model_txn(w, a, d, known, ed, ee);
        txn(name, w, a, d, perturb, p_addr, known, ed, ee);
    endtask

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        bit known, ee;
        logic [31:0] ed;

        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 32'h0000_0013, 32'h0102_0304, 32'h0102_0304};
        vecs[3] = '{1'b0, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0102_0304};
        vecs[4] = '{1'b1, 32'h0000_0020, 32'hCAFE_F00D, 32'hCAFE_F00D};
        vecs[5] = '{1'b0, 32'h0000_0020, 32'h0000_0000, 32'hCAFE_F00D};
        vecs[6] = '{1'b1, 32'h0000_0000, 32'h1122_3344, 32'h1122_3344};
        vecs[7] = '{1'b0, 32'h0000_0003, 32'h0000_0000, 32'h1122_3344};

        req1 = 1'b0; we1 = 1'b0; addr1 = 32'h0; din1 = to_word(32'h0);

        // Reset held two cycles with a live request.
        rst_b = 1'b0; req = 1'b1; we = 1'b1; addr = 32'h10; din = to_word(32'h55AA_55AA);
        for (int i = 0; i < 2; i++) begin
            step();
            check("reset ready", 32'(ready), 32'd0);
            check("reset busy", 32'(busy), 32'd0);
            check("reset err", 32'(err), 32'd0);
            check("reset data_out", from_word(dout), 32'h0);
        end
        check("reset ready1", 32'(ready1), 32'd0);
        check("reset busy1", 32'(busy1), 32'd0);
        rst_b = 1'b1; req = 1'b0;
        step();
        check("post-reset no accept", 32'(busy), 32'd0);

        for (int i = 0; i < 8; i++) begin
            model_txn(vecs[i].we, vecs[i].addr, vecs[i].data, known, ed, ee);
            txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].data, 1'b0, 32'h0,
                1'b1, vecs[i].exp, 1'b0);
        end

        // Request held through BUSY/DONE while address/data/we wander to word 8.
        model_and_txn("busy_ignore_wr", 1'b1, 32'h0000_0030, 32'hA1B2_C3D4, 1'b1, 32'h0000_0020);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (ready) pulses++;
        end
        check("busy_ignore extra pulses", 32'(pulses), 32'd0);
        txn("busy_ignore rd20", 1'b0, 32'h20, 32'h0, 1'b0, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0);
        txn("busy_ignore rd30", 1'b0, 32'h30, 32'h0, 1'b0, 32'h0, 1'b1, 32'hA1B2_C3D4, 1'b0);

        // Reset two cycles into a write aborts it.
        model_and_txn("abort_pre", 1'b1, 32'h0000_0040, 32'h0BAD_F00D, 1'b0, 32'h0);
        req = 1'b1; we = 1'b1; addr = 32'h40; din = to_word(32'hFFFF_0000);
        step();
        req = 1'b0;
        step();
        step();
        rst_b = 1'b0;
        step();
        rst_b = 1'b1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort data_out", from_word(dout), 32'h0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (ready) pulses++;
        end
        check("abort pulses", 32'(pulses), 32'd0);
        txn("abort rd40", 1'b0, 32'h40, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0BAD_F00D, 1'b0);

        // Address beyond storage depth.
        model_and_txn("range_pre", 1'b1, 32'h0000_0000, 32'h1111_1111, 1'b0, 32'h0);
        model_and_txn("range_wr", 1'b1, 32'h0001_0000, 32'h7777_7777, 1'b0, 32'h0);
        model_and_txn("range_rd0", 1'b0, 32'h0000_0000, 32'h0, 1'b0, 32'h0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, d, pa;
            bit w;
            w = 1'($urandom_range(0, 1));
            a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(AW + 2, 31));
            d = $urandom;
            pa = 32'($urandom_range(0, 15)) << 2;
            model_and_txn($sformatf("rand%0d", i), w, a, d, 1'($urandom_range(0, 1)), pa);
        end

        // LATENCY=1 with a continuously held request: BUSY, DONE, IDLE per request.
        req1 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            check($sformatf("b2b ready c%0d", i), 32'(ready1), 32'((i % 3) == 1));
            check($sformatf("b2b busy c%0d", i), 32'(busy1), 32'((i % 3) != 2));
        end
        req1 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
